// File: rtl/spram_pkg.sv
// Shared constants for the banked-lane single-port RAM family.
package spram_pkg;

    localparam int RDW_HOLD          = 0;
    localparam int RDW_WRITE_THROUGH = 1;

    localparam logic ST_CLEAR = 1'b0;
    localparam logic ST_IDLE  = 1'b1;

endpackage

// File: rtl/spram_lane.sv
// One lane of the banked RAM: LANE_WIDTH x NUM_WORDS, own write enable, registered read.
module spram_lane #(
    parameter int AWIDTH     = 12,
    parameter int NUM_WORDS  = 4096,
    parameter int LANE_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic                  re,
    input  logic [AWIDTH-1:0]     addr,
    input  logic [LANE_WIDTH-1:0] d,
    output logic [LANE_WIDTH-1:0] q
);

`ifdef hard_mem
    single_port_ram #(
        .ADDR_WIDTH (AWIDTH),
        .DATA_WIDTH (LANE_WIDTH),
        .DEPTH      (NUM_WORDS)
    ) u_ram (
        .clk  (clk),
        .we   (we),
        .re   (re),
        .addr (addr),
        .d    (d),
        .q    (q)
    );
`else
    logic [LANE_WIDTH-1:0] mem [NUM_WORDS];

    // Read-first: a same-cycle write is not visible on q; the top bypasses it when needed.
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= d;
        if (re) q <= mem[addr];
    end
`endif

endmodule

// File: rtl/spram_banked_lanes.sv
// Parametrised single-port RAM with per-lane write enables, RDW mode, optional output
// register, post-reset zero-clear sweep and a read-valid strobe.
module spram_banked_lanes
    import spram_pkg::*;
#(
    parameter int AWIDTH     = 12,
    parameter int NUM_WORDS  = 4096,
    parameter int LANE_WIDTH = 12,
    parameter int NUM_LANES  = 5,
    parameter int OUT_REG    = 1,
    parameter int RDW_MODE   = 0,
    parameter int CLEAR_EN   = 1,
    localparam int DWIDTH    = LANE_WIDTH * NUM_LANES
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [AWIDTH-1:0]    address,
    input  logic                 wren,
    input  logic                 rden,
    input  logic [NUM_LANES-1:0] lane_en,
    input  logic [DWIDTH-1:0]    data,
    output logic [DWIDTH-1:0]    out,
    output logic                 out_valid,
    output logic                 busy
);

    logic              state;
    logic [AWIDTH:0]   clr_cnt;
    logic              clearing;
    logic              idle;
    logic              in_range;
    logic              user_wr;
    logic              rd_issue;
    logic [AWIDTH-1:0] mem_addr;
    logic [DWIDTH-1:0] q_word;

    logic                 v1;
    logic                 oor1;
    logic [NUM_LANES-1:0] byp_en1;
    logic [DWIDTH-1:0]    byp_data1;
    logic [DWIDTH-1:0]    rd_word;

    assign busy     = (state == ST_CLEAR);
    assign clearing = !reset && (state == ST_CLEAR);
    assign idle     = !reset && (state == ST_IDLE);
    assign in_range = ({1'b0, address} < (AWIDTH+1)'(NUM_WORDS));
    assign user_wr  = idle && wren && in_range;
    assign rd_issue = idle && rden && (!wren || (RDW_MODE == RDW_WRITE_THROUGH));
    assign mem_addr = clearing ? clr_cnt[AWIDTH-1:0] : address;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= (CLEAR_EN != 0) ? ST_CLEAR : ST_IDLE;
            clr_cnt <= '0;
        end else if (state == ST_CLEAR) begin
            clr_cnt <= clr_cnt + 1'b1;
            if (clr_cnt == (AWIDTH+1)'(NUM_WORDS - 1)) state <= ST_IDLE;
        end
    end

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        spram_lane #(
            .AWIDTH     (AWIDTH),
            .NUM_WORDS  (NUM_WORDS),
            .LANE_WIDTH (LANE_WIDTH)
        ) u_lane (
            .clk  (clk),
            .we   (clearing || (user_wr && lane_en[i])),
            .re   (rd_issue && in_range),
            .addr (mem_addr),
            .d    (clearing ? '0 : data[i*LANE_WIDTH +: LANE_WIDTH]),
            .q    (q_word[i*LANE_WIDTH +: LANE_WIDTH])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) v1 <= 1'b0;
        else       v1 <= rd_issue;
    end

    // Write-through merge: lanes written in the read cycle come from the captured data.
    always_ff @(posedge clk) begin
        if (rd_issue) begin
            oor1      <= !in_range;
            byp_en1   <= (wren && in_range) ? lane_en : '0;
            byp_data1 <= data;
        end
    end

    always_comb begin
        rd_word = '0;
        if (!oor1) begin
            for (int unsigned i = 0; i < NUM_LANES; i++) begin
                rd_word[i*LANE_WIDTH +: LANE_WIDTH] = byp_en1[i] ? byp_data1[i*LANE_WIDTH +: LANE_WIDTH]
                                                                 : q_word[i*LANE_WIDTH +: LANE_WIDTH];
            end
        end
    end

    if (OUT_REG != 0) begin : g_oreg
        logic              v2;
        logic [DWIDTH-1:0] out_r;

        always_ff @(posedge clk) begin
            if (reset) begin
                v2    <= 1'b0;
                out_r <= '0;
            end else begin
                v2 <= v1;
                if (v1) out_r <= rd_word;
            end
        end

        assign out       = out_r;
        assign out_valid = v2;
    end else begin : g_noreg
        logic [DWIDTH-1:0] hold;

        // Latency 1 presents rd_word directly; hold keeps the last result between reads.
        always_ff @(posedge clk) begin
            if (reset)   hold <= '0;
            else if (v1) hold <= rd_word;
        end

        assign out       = v1 ? rd_word : hold;
        assign out_valid = v1;
    end

endmodule

// File: tb/tb_spram_banked_lanes.sv
// Scoreboard bench: two configurations driven with identical directed stimulus.
module tb_spram_banked_lanes;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wren = 1'b0;
    logic        rden = 1'b0;
    logic [11:0] address = '0;
    logic [4:0]  lane_en = '0;
    logic [59:0] data = '0;

    logic [59:0] out_a, out_b;
    logic        valid_a, valid_b, busy_a, busy_b;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [59:0] qa_data[$];
    int          qa_cyc[$];
    logic [59:0] qb_data[$];
    int          qb_cyc[$];
    string       dq_name[$];
    logic [63:0] dq_act[$];
    logic [63:0] dq_exp[$];

    localparam logic [59:0] D1 = 60'h0AB_CDE_F01_234_567;
    localparam logic [59:0] D2 = 60'h0AB_CDE_FFF_234_567;
    localparam logic [59:0] D3 = 60'h0AB_CDE_FFF_234_ABC;
    localparam logic [59:0] W1 = 60'h111_111_111_111_111;
    localparam logic [59:0] W2 = 60'h222_333_444_555_666;
    localparam logic [59:0] W3 = 60'h987_654_321_0FE_DCB;
    localparam logic [59:0] W4 = 60'hABC_DEF_012_345_678;

    spram_banked_lanes #(
        .AWIDTH(12), .NUM_WORDS(4096), .LANE_WIDTH(12), .NUM_LANES(5),
        .OUT_REG(1), .RDW_MODE(0), .CLEAR_EN(1)
    ) ua (
        .clk(clk), .reset(reset), .address(address), .wren(wren), .rden(rden),
        .lane_en(lane_en), .data(data), .out(out_a), .out_valid(valid_a), .busy(busy_a)
    );

    spram_banked_lanes #(
        .AWIDTH(12), .NUM_WORDS(4000), .LANE_WIDTH(12), .NUM_LANES(5),
        .OUT_REG(0), .RDW_MODE(1), .CLEAR_EN(1)
    ) ub (
        .clk(clk), .reset(reset), .address(address), .wren(wren), .rden(rden),
        .lane_en(lane_en), .data(data), .out(out_b), .out_valid(valid_b), .busy(busy_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        logic [59:0] d;
        int          c;
        logic [63:0] act, exp;
        string       nm;
        if (valid_a) begin
            checks++;
            if (qa_data.size() == 0) begin
                failures++;
                $display("FAIL a_unexpected_valid actual out=%h required no out_valid", out_a);
            end else begin
                d = qa_data.pop_front();
                c = qa_cyc.pop_front();
                if (out_a !== d || cyc - c != 2) begin
                    failures++;
                    $display("FAIL a_read actual=%h lat=%0d required=%h lat=2", out_a, cyc - c, d);
                end
            end
        end
        if (valid_b) begin
            checks++;
            if (qb_data.size() == 0) begin
                failures++;
                $display("FAIL b_unexpected_valid actual out=%h required no out_valid", out_b);
            end else begin
                d = qb_data.pop_front();
                c = qb_cyc.pop_front();
                if (out_b !== d || cyc - c != 1) begin
                    failures++;
                    $display("FAIL b_read actual=%h lat=%0d required=%h lat=1", out_b, cyc - c, d);
                end
            end
        end
        while (dq_name.size() > 0) begin
            nm  = dq_name.pop_front();
            act = dq_act.pop_front();
            exp = dq_exp.pop_front();
            checks++;
            if (act !== exp) begin
                failures++;
                $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_a(input logic [59:0] d);
        qa_data.push_back(d);
        qa_cyc.push_back(cyc);
    endtask

    task automatic expect_b(input logic [59:0] d);
        qb_data.push_back(d);
        qb_cyc.push_back(cyc);
    endtask

    task automatic direct(input string n, input logic [63:0] act, input logic [63:0] exp);
        dq_name.push_back(n);
        dq_act.push_back(act);
        dq_exp.push_back(exp);
    endtask

    task automatic req(input logic w, input logic r, input logic [11:0] a,
                       input logic [4:0] en, input logic [59:0] d);
        wren = w; rden = r; address = a; lane_en = en; data = d;
        step();
        wren = 1'b0; rden = 1'b0; lane_en = '0;
    endtask

    // Counts cycles until each DUT drops busy; optionally pokes requests mid-sweep.
    task automatic sweep(input bit poke, output int na, output int nb);
        int n = 0;
        na = -1;
        nb = -1;
        while ((busy_a || busy_b) && n < 10000) begin
            if (poke && n == 50) begin wren = 1'b1; address = 12'd5; lane_en = '1; data = '1; end
            if (poke && n == 60) begin rden = 1'b1; address = 12'd5; end
            if (poke && n == 70) begin wren = 1'b1; rden = 1'b1; address = 12'd5; lane_en = '1; data = '1; end
            step();
            wren = 1'b0; rden = 1'b0; lane_en = '0;
            n++;
            if (!busy_a && na < 0) na = n;
            if (!busy_b && nb < 0) nb = n;
        end
    endtask

    initial begin
        int na, nb;

        step();
        reset = 1'b0;
        direct("a_reset_out", {4'h0, out_a}, 64'h0);
        direct("a_reset_valid", {63'h0, valid_a}, 64'h0);
        direct("a_reset_busy", {63'h0, busy_a}, 64'h1);
        direct("b_reset_busy", {63'h0, busy_b}, 64'h1);
        sweep(1'b0, na, nb);
        direct("a_sweep_len", 64'(na), 64'd4096);
        direct("b_sweep_len", 64'(nb), 64'd4000);

        expect_a('0); expect_b('0); req(1'b0, 1'b1, 12'd0,    '0, '0);
        expect_a('0); expect_b('0); req(1'b0, 1'b1, 12'd2048, '0, '0);
        expect_a('0); expect_b('0); req(1'b0, 1'b1, 12'd4095, '0, '0);

        req(1'b1, 1'b0, 12'd5, 5'b11111, D1);
        req(1'b1, 1'b0, 12'd5, 5'b00100, '1);
        expect_a(D2); expect_b(D2); req(1'b0, 1'b1, 12'd5, '0, '0);

        expect_b(60'h123); req(1'b1, 1'b1, 12'd9, 5'b11111, 60'h123);
        expect_a(60'h123); expect_b(60'h123); req(1'b0, 1'b1, 12'd9, '0, '0);
        expect_b(D3); req(1'b1, 1'b1, 12'd5, 5'b00001, 60'hABC);
        req(1'b1, 1'b0, 12'd5, 5'b00000, '1);
        expect_a(D3); expect_b(D3); req(1'b0, 1'b1, 12'd5, '0, '0);

        req(1'b1, 1'b0, 12'd1, 5'b11111, W1);
        req(1'b1, 1'b0, 12'd2, 5'b11111, W2);
        req(1'b1, 1'b0, 12'd3, 5'b11111, W3);
        expect_a(W1); expect_b(W1); req(1'b0, 1'b1, 12'd1, '0, '0);
        expect_a(W2); expect_b(W2); req(1'b0, 1'b1, 12'd2, '0, '0);
        expect_a(W3); expect_b(W3); req(1'b0, 1'b1, 12'd3, '0, '0);
        step(); step(); step();
        direct("a_out_hold", {4'h0, out_a}, {4'h0, W3});
        direct("b_out_hold", {4'h0, out_b}, {4'h0, W3});

        req(1'b1, 1'b0, 12'd4000, 5'b11111, W4);
        expect_a(W4); expect_b('0); req(1'b0, 1'b1, 12'd4000, '0, '0);
        expect_a('0); expect_b('0); req(1'b0, 1'b1, 12'd4095, '0, '0);
        expect_b('0); req(1'b1, 1'b1, 12'd4001, 5'b11111, '1);
        step(); step();

        // Read in flight when reset arrives: only the latency-1 DUT has already presented it.
        expect_b(D3);
        rden = 1'b1; address = 12'd5;
        step();
        rden = 1'b0; reset = 1'b1;
        step();
        reset = 1'b0;
        direct("a_rst_out", {4'h0, out_a}, 64'h0);
        for (int i = 0; i < 100; i++) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        sweep(1'b1, na, nb);
        direct("a_resweep_len", 64'(na), 64'd4096);
        direct("b_resweep_len", 64'(nb), 64'd4000);

        expect_a('0); expect_b('0); req(1'b0, 1'b1, 12'd5, '0, '0);
        expect_a('0); expect_b('0); req(1'b0, 1'b1, 12'd9, '0, '0);
        for (int i = 0; i < 4; i++) step();
        direct("a_pending", 64'(qa_data.size()), 64'd0);
        direct("b_pending", 64'(qb_data.size()), 64'd0);
        step(); step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
